// File: rtl/datapath_pkg.sv
// Shared widths and reset constant for the single-bus datapath slice.
package datapath_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned Z_WIDTH    = 2 * DATA_WIDTH;

  localparam logic [DATA_WIDTH-1:0] RESET_VAL = DATA_WIDTH'(32'h0);

endpackage

// File: rtl/datapath_reg32.sv
// Load-enabled register with synchronous clear; the basic storage cell of the datapath.
module datapath_reg32
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en_i) q_d = d_i;
  end

  always_ff @(posedge clock) begin
    if (clear) q_q <= WIDTH'(RESET_VAL);
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath slice: strobe-driven bus mux, register file
// fragment, MDR, IR, Y/Z with a bitwise-AND ALU, and HI/LO result registers.
module datapath
  import datapath_pkg::*;
(
  input  logic                  clock,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] Mdatain,
  input  logic                  Read,
  input  logic                  MDRin,
  input  logic                  MDRout,
  input  logic                  R1in,
  input  logic                  R4in,
  input  logic                  R5in,
  input  logic                  R4out,
  input  logic                  R5out,
  input  logic                  Yin,
  input  logic                  IRin,
  input  logic                  AND,
  input  logic                  Zlowout,
  input  logic                  ZHighout,
  input  logic                  LOin,
  input  logic                  HIin,
  input  logic                  PCout,
  output logic [DATA_WIDTH-1:0] BusMuxOut,
  output logic [DATA_WIDTH-1:0] R1q,
  output logic [DATA_WIDTH-1:0] R4q,
  output logic [DATA_WIDTH-1:0] R5q,
  output logic [DATA_WIDTH-1:0] IRq,
  output logic [DATA_WIDTH-1:0] Yq,
  output logic [DATA_WIDTH-1:0] HIq,
  output logic [DATA_WIDTH-1:0] LOq,
  output logic [DATA_WIDTH-1:0] MDRq,
  output logic [Z_WIDTH-1:0]    Zq
);

  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] mdr_d;
  logic [DATA_WIDTH-1:0] z_lo_d;
  logic [DATA_WIDTH-1:0] z_hi_d;

  // Priority bus mux; overlapping out-strobes resolve to the highest-priority source.
  always_comb begin
    BusMuxOut = DATA_WIDTH'(0);
    if (MDRout)        BusMuxOut = MDRq;
    else if (Zlowout)  BusMuxOut = Zq[DATA_WIDTH-1:0];
    else if (ZHighout) BusMuxOut = Zq[Z_WIDTH-1:DATA_WIDTH];
    else if (PCout)    BusMuxOut = pc_q;
    else if (R4out)    BusMuxOut = R4q;
    else if (R5out)    BusMuxOut = R5q;
  end

  always_comb begin
    mdr_d  = Read ? Mdatain : BusMuxOut;
    z_lo_d = Yq & BusMuxOut;
    z_hi_d = DATA_WIDTH'(0);
  end

  datapath_reg32 u_r1  (.clock(clock), .clear(clear), .en_i(R1in),  .d_i(BusMuxOut), .q_o(R1q));
  datapath_reg32 u_r4  (.clock(clock), .clear(clear), .en_i(R4in),  .d_i(BusMuxOut), .q_o(R4q));
  datapath_reg32 u_r5  (.clock(clock), .clear(clear), .en_i(R5in),  .d_i(BusMuxOut), .q_o(R5q));
  datapath_reg32 u_mdr (.clock(clock), .clear(clear), .en_i(MDRin), .d_i(mdr_d),     .q_o(MDRq));
  datapath_reg32 u_ir  (.clock(clock), .clear(clear), .en_i(IRin),  .d_i(BusMuxOut), .q_o(IRq));
  datapath_reg32 u_y   (.clock(clock), .clear(clear), .en_i(Yin),   .d_i(BusMuxOut), .q_o(Yq));
  datapath_reg32 u_hi  (.clock(clock), .clear(clear), .en_i(HIin),  .d_i(BusMuxOut), .q_o(HIq));
  datapath_reg32 u_lo  (.clock(clock), .clear(clear), .en_i(LOin),  .d_i(BusMuxOut), .q_o(LOq));

  // PC has no load path here; it only supplies its reset value to the bus.
  datapath_reg32 u_pc  (.clock(clock), .clear(clear), .en_i(1'b0),  .d_i(DATA_WIDTH'(0)), .q_o(pc_q));

  datapath_reg32 u_z_lo (.clock(clock), .clear(clear), .en_i(AND), .d_i(z_lo_d),
                         .q_o(Zq[DATA_WIDTH-1:0]));
  datapath_reg32 u_z_hi (.clock(clock), .clear(clear), .en_i(AND), .d_i(z_hi_d),
                         .q_o(Zq[Z_WIDTH-1:DATA_WIDTH]));

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for datapath: directed strobe sequences push expected
// observations; a negedge monitor pops and compares them.
module tb_datapath;

  logic        clock;
  logic        clear;
  logic [31:0] Mdatain;
  logic        Read, MDRin, MDRout;
  logic        R1in, R4in, R5in, R4out, R5out;
  logic        Yin, IRin, AND, Zlowout, ZHighout, LOin, HIin, PCout;
  logic [31:0] BusMuxOut, R1q, R4q, R5q, IRq, Yq, HIq, LOq, MDRq;
  logic [63:0] Zq;

  datapath dut (
    .clock(clock), .clear(clear), .Mdatain(Mdatain), .Read(Read), .MDRin(MDRin),
    .MDRout(MDRout), .R1in(R1in), .R4in(R4in), .R5in(R5in), .R4out(R4out),
    .R5out(R5out), .Yin(Yin), .IRin(IRin), .AND(AND), .Zlowout(Zlowout),
    .ZHighout(ZHighout), .LOin(LOin), .HIin(HIin), .PCout(PCout),
    .BusMuxOut(BusMuxOut), .R1q(R1q), .R4q(R4q), .R5q(R5q), .IRq(IRq), .Yq(Yq),
    .HIq(HIq), .LOq(LOq), .MDRq(MDRq), .Zq(Zq)
  );

  localparam int S_BUS = 0, S_R1 = 1, S_R4 = 2, S_R5 = 3, S_IR = 4, S_Y = 5,
                 S_HI = 6, S_LO = 7, S_MDR = 8, S_ZLO = 9, S_ZHI = 10;

  typedef struct {
    int unsigned cyc;
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] sample(int sig);
    case (sig)
      S_BUS:   return BusMuxOut;
      S_R1:    return R1q;
      S_R4:    return R4q;
      S_R5:    return R5q;
      S_IR:    return IRq;
      S_Y:     return Yq;
      S_HI:    return HIq;
      S_LO:    return LOq;
      S_MDR:   return MDRq;
      S_ZLO:   return Zq[31:0];
      default: return Zq[63:32];
    endcase
  endfunction

  // Monitor: compare every expectation that has come due this cycle.
  exp_t        mon_e;
  logic [31:0] mon_act;
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e   = sb.pop_front();
      mon_act = sample(mon_e.sig);
      checks++;
      if (mon_act !== mon_e.val) begin
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                 mon_e.name, mon_act, mon_e.val, cyc);
      end
    end
  end

  task automatic exp_now(int sig, logic [31:0] v, string n);
    exp_t e;
    e.cyc = cyc; e.sig = sig; e.val = v; e.name = n;
    sb.push_back(e);
  endtask

  task automatic exp_next(int sig, logic [31:0] v, string n);
    exp_t e;
    e.cyc = cyc + 1; e.sig = sig; e.val = v; e.name = n;
    sb.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
    clear = 1'b0; Read = 1'b0; MDRin = 1'b0; MDRout = 1'b0;
    R1in = 1'b0; R4in = 1'b0; R5in = 1'b0; R4out = 1'b0; R5out = 1'b0;
    Yin = 1'b0; IRin = 1'b0; AND = 1'b0; Zlowout = 1'b0; ZHighout = 1'b0;
    LOin = 1'b0; HIin = 1'b0; PCout = 1'b0;
  endtask

  task automatic load_mdr(logic [31:0] v);
    next_cycle(); Mdatain = v; Read = 1'b1; MDRin = 1'b1;
    exp_next(S_MDR, v, "mdr_load");
  endtask

  initial begin
    clear = 1'b1; Mdatain = '0; Read = 1'b0; MDRin = 1'b0; MDRout = 1'b0;
    R1in = 1'b0; R4in = 1'b0; R5in = 1'b0; R4out = 1'b0; R5out = 1'b0;
    Yin = 1'b0; IRin = 1'b0; AND = 1'b0; Zlowout = 1'b0; ZHighout = 1'b0;
    LOin = 1'b0; HIin = 1'b0; PCout = 1'b0;

    next_cycle(); clear = 1'b1;

    // Arbitrary loads, then a clear that overrides live enables.
    load_mdr(32'hDEAD_BEEF);
    next_cycle(); MDRout = 1'b1; R1in = 1'b1; R4in = 1'b1; R5in = 1'b1; IRin = 1'b1;
    Yin = 1'b1; LOin = 1'b1; HIin = 1'b1;
    exp_now(S_BUS, 32'hDEAD_BEEF, "bus_mdr_arbitrary");
    exp_next(S_R4, 32'hDEAD_BEEF, "r4_arbitrary");
    exp_next(S_HI, 32'hDEAD_BEEF, "hi_arbitrary");
    next_cycle(); clear = 1'b1; Mdatain = 32'h1234; Read = 1'b1; MDRin = 1'b1;
    R4out = 1'b1; R1in = 1'b1;
    exp_now(S_BUS, 32'hDEAD_BEEF, "bus_r4_pre_clear");
    exp_next(S_R1, 32'h0, "rst_r1");   exp_next(S_R4, 32'h0, "rst_r4");
    exp_next(S_R5, 32'h0, "rst_r5");   exp_next(S_IR, 32'h0, "rst_ir");
    exp_next(S_Y, 32'h0, "rst_y");     exp_next(S_HI, 32'h0, "rst_hi");
    exp_next(S_LO, 32'h0, "rst_lo");   exp_next(S_MDR, 32'h0, "rst_mdr");
    exp_next(S_ZLO, 32'h0, "rst_zlo"); exp_next(S_ZHI, 32'h0, "rst_zhi");
    next_cycle();
    exp_now(S_BUS, 32'h0, "bus_idle_zero");

    // MDR path: Mdatain is ignored once Read drops.
    load_mdr(32'h12);
    next_cycle(); Mdatain = 32'h02; MDRout = 1'b1; R4in = 1'b1;
    exp_now(S_BUS, 32'h12, "bus_mdr_12");
    exp_next(S_R4, 32'h12, "r4_from_mdr");
    exp_next(S_MDR, 32'h12, "mdr_hold");

    // Register chain and HI preload.
    load_mdr(32'h77);
    next_cycle(); MDRout = 1'b1; HIin = 1'b1;
    exp_next(S_HI, 32'h77, "hi_preload");
    load_mdr(32'h04);
    next_cycle(); MDRout = 1'b1; R5in = 1'b1;
    exp_next(S_R5, 32'h04, "r5_load");
    load_mdr(32'h0C);
    next_cycle(); MDRout = 1'b1; IRin = 1'b1;
    exp_next(S_IR, 32'h0C, "ir_load");
    exp_next(S_R5, 32'h04, "r5_hold");

    // AND operation through Y and Z.
    load_mdr(32'h1F);
    next_cycle(); MDRout = 1'b1; R4in = 1'b1;
    exp_next(S_R4, 32'h1F, "r4_1f");
    next_cycle(); R4out = 1'b1; Yin = 1'b1;
    exp_now(S_BUS, 32'h1F, "bus_r4_1f");
    exp_next(S_Y, 32'h1F, "y_load");
    load_mdr(32'h14);
    next_cycle(); MDRout = 1'b1; R5in = 1'b1;
    exp_next(S_R5, 32'h14, "r5_14");
    next_cycle(); R5out = 1'b1; AND = 1'b1;
    exp_next(S_ZLO, 32'h14, "z_lo_and");
    exp_next(S_ZHI, 32'h0, "z_hi_and");
    next_cycle(); Zlowout = 1'b1; LOin = 1'b1;
    exp_now(S_BUS, 32'h14, "bus_zlow");
    exp_next(S_LO, 32'h14, "lo_load");
    next_cycle(); ZHighout = 1'b1; HIin = 1'b1;
    exp_now(S_BUS, 32'h0, "bus_zhigh");
    exp_next(S_HI, 32'h0, "hi_from_zhigh");
    exp_next(S_ZLO, 32'h14, "z_hold");

    // Same-cycle read-after-write reloads the pre-edge value.
    next_cycle(); R4out = 1'b1; R4in = 1'b1;
    exp_now(S_BUS, 32'h1F, "bus_r4_self");
    exp_next(S_R4, 32'h1F, "r4_self_reload");

    // Bus priority cases.
    next_cycle(); Zlowout = 1'b1; R5out = 1'b1;
    exp_now(S_BUS, 32'h14, "prio_zlow_over_r5");
    next_cycle(); PCout = 1'b1; R4out = 1'b1;
    exp_now(S_BUS, 32'h0, "prio_pc_over_r4");
    load_mdr(32'h55);
    next_cycle(); MDRout = 1'b1; R4in = 1'b1;
    exp_next(S_R4, 32'h55, "r4_55");
    load_mdr(32'hAA);
    next_cycle(); MDRout = 1'b1; R4out = 1'b1; R1in = 1'b1;
    exp_now(S_BUS, 32'hAA, "prio_mdr_over_r4");
    exp_next(S_R1, 32'hAA, "r1_prio");

    // MDR loads from the bus when Read is low.
    next_cycle(); Mdatain = 32'hFF; R5out = 1'b1; MDRin = 1'b1;
    exp_next(S_MDR, 32'h14, "mdr_from_bus");

    // Clear on the same edge as AND and LOin discards those loads.
    next_cycle(); clear = 1'b1; R5out = 1'b1; AND = 1'b1; LOin = 1'b1;
    exp_now(S_BUS, 32'h14, "bus_before_midrst");
    exp_next(S_ZLO, 32'h0, "midrst_zlo");
    exp_next(S_LO, 32'h0, "midrst_lo");
    exp_next(S_Y, 32'h0, "midrst_y");

    next_cycle();
    next_cycle();
    for (int i = 0; i < 8 && sb.size() > 0; i++) @(negedge clock);
    #1;

    // Final quiet state after the mid-sequence clear.
    checks++;
    if (Zq !== 64'h0) begin
      errors++; $display("FAIL final_z: got 0x%016h expected 0", Zq);
    end
    checks++;
    if (LOq !== 32'h0) begin
      errors++; $display("FAIL final_lo: got 0x%08h expected 0", LOq);
    end
    checks++;
    if (Yq !== 32'h0) begin
      errors++; $display("FAIL final_y: got 0x%08h expected 0", Yq);
    end
    checks++;
    if (R1q !== 32'h0) begin
      errors++; $display("FAIL final_r1: got 0x%08h expected 0", R1q);
    end
    checks++;
    if (R4q !== 32'h0) begin
      errors++; $display("FAIL final_r4: got 0x%08h expected 0", R4q);
    end
    checks++;
    if (MDRq !== 32'h0) begin
      errors++; $display("FAIL final_mdr: got 0x%08h expected 0", MDRq);
    end
    checks++;
    if (BusMuxOut !== 32'h0) begin
      errors++; $display("FAIL final_bus: got 0x%08h expected 0", BusMuxOut);
    end

    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: never compared, expected 0x%08h", mon_e.name, mon_e.val);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- Single-bus 32-bit CPU datapath slice.
- The internal bus is fed by a one-hot set of out-strobes.
- Registers capture from the bus on their in-strobes.
- Contents: general registers R1/R4/R5, MDR with memory-data input, IR, Y operand latch, 64-bit Z result register from a bitwise-AND ALU, and HI/LO result registers.
- An external control sequencer drives every strobe; this block contains no FSM.

Parameters:
- DATA_WIDTH, 32, width of the bus and of every register except Z (Z is 2*DATA_WIDTH).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  synchronous active-high reset.
- Mdatain  in  32  memory read data into the MDR.
- Read  in  1  MDR input select: 1 = Mdatain, 0 = bus.
- MDRin  in  1  MDR load enable.
- MDRout  in  1  drive MDR onto the bus.
- R1in, R4in, R5in  in  1 each  load R1/R4/R5 from the bus.
- R4out, R5out  in  1 each  drive R4/R5 onto the bus.
- Yin  in  1  load Y from the bus.
- IRin  in  1  load IR from the bus.
- AND  in  1  ALU strobe: Z <= {32'b0, Y & bus}.
- Zlowout  in  1  drive Z[31:0] onto the bus.
- ZHighout  in  1  drive Z[63:32] onto the bus.
- LOin, HIin  in  1 each  load LO/HI from the bus.
- PCout  in  1  drive PC onto the bus.
- BusMuxOut  out  32  current bus value (observation).
- R1q, R4q, R5q, IRq, Yq, HIq, LOq, MDRq  out  32 each  register contents (observation).
- Zq  out  64  Z contents (observation).

Behaviour:
- Reset: clear sampled high at a rising edge sets R1, R4, R5, MDR, IR, Y, Z, HI, LO and PC to 0.
  - Reset overrides every enable.
  - Reset mid-sequence discards that cycle's loads.
- Register loads: each register captures on the rising edge where its in-strobe is high.
  - Otherwise it holds its value.
  - Load latency is 1 cycle; the new value is visible on its observation output after that edge.
- MDR input mux: Read ? Mdatain : BusMuxOut.
  - Mdatain is ignored unless Read=1 and MDRin=1.
- Bus: combinational priority mux, highest priority first:
  - MDRout, Zlowout, ZHighout, PCout, R4out, R5out.
  - No out-strobe asserted: bus = 0.
  - Multiple strobes asserted: the highest-priority source wins; this is legal and defined.
- ALU: Z loads on the edge where AND=1.
  - Z[31:0] = Yq & BusMuxOut; Z[63:32] = 0.
  - AND=0: Z holds.
- PC: 32-bit register, reset 0, with no load path in this block. It holds 0 and is readable via PCout.
- Read-after-write in the same cycle: a source register's out value is its pre-edge value.
  - Example: R4out and R4in high together reloads R4 with its own value.
- All observation outputs are direct register or bus values; no extra latency.

Decomposition:
- Shared package holds DATA_WIDTH and the reset value constant (32'h0).
- Natural sub-module: reg32, a parameterised register with synchronous clear and load enable. It is instantiated for R1, R4, R5, MDR, IR, Y, HI, LO and PC.
- Z is built from two reg32 instances sharing the AND enable.
- The bus mux and ALU stay in datapath.

Test Plan:
- Reset: hold clear=1 for one edge after arbitrary loads -> all observation outputs 0; BusMuxOut=0 with no strobes.
- MDR path:
  - Mdatain=0x12, Read=1, MDRin=1 for one cycle -> MDRq=0x12.
  - Next cycle Mdatain=0x02, Read=0, MDRout=1, R4in=1 -> R4q=0x12 (Mdatain change ignored).
- Register chain: load R5=0x04 via MDR, then Mdatain=0x0C via MDR with MDRout+IRin -> R5q=0x04, IRq=0x0C.
- AND op:
  - R4=0x1F: R4out+Yin -> Yq=0x1F.
  - R5=0x14: R5out+AND -> Zq=0x0000_0000_0000_0014.
  - Zlowout+LOin -> LOq=0x14.
  - ZHighout+HIin -> HIq=0.
- Bus priority: MDR=0xAA, R4=0x55, MDRout and R4out together -> BusMuxOut=0xAA; R1in captures 0xAA.
- Reset mid-operation: clear=1 on the same edge as AND=1 and LOin=1 -> Zq=0, LOq=0.
